// File: rtl/knockout_pkg.sv
// Shared types and constants for the instruction knockout injector.
// Optional feature macro: KNOCKOUT_CNT_EN (adds the knocked_cnt output).
package knockout_pkg;

    localparam int unsigned INST_W = 32;

    // Default substituted word: RISC-V "addi x0, x0, 0".
    localparam logic [INST_W-1:0] NOP_DEFAULT = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_KNOCK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/knockout_slice.sv
// Single-stage valid/ready register slice; ready depends only on the
// registered valid and the downstream ready, never on the upstream valid.
module knockout_slice
    import knockout_pkg::*;
#(
    parameter int unsigned W = INST_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic beat;

    assign in_ready = !out_valid | out_ready;
    assign beat     = in_valid & in_ready;

    // Load on an accepted beat, drain when the consumer takes the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (beat) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/knockout_injector.sv
// Instruction-stream knockout injector: after an armed trigger and a
// programmable number of accepted beats, replaces a programmable number of
// beats with NOP_INST.
// Optional feature macro: KNOCKOUT_CNT_EN adds knocked_cnt[15:0], a
// saturating count of replaced beats that survives re-arming.
module knockout_injector
    import knockout_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_DEFAULT,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             trig,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic [31:0]      in_inst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             active,
    output logic             done
`ifdef KNOCKOUT_CNT_EN
    ,
    output logic [15:0]      knocked_cnt
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] sh_delay;
    logic [CNT_W-1:0] sh_delay_nxt;
    logic [CNT_W-1:0] sh_len;
    logic [CNT_W-1:0] sh_len_nxt;
    logic             beat;
    logic [31:0]      slice_data;

    assign beat    = in_valid & in_ready;
    assign cnt_inc = cnt + CNT_W'(1);

    // Payload substitution happens on the way into the register slice.
    assign slice_data = (state == ST_KNOCK) ? NOP_INST : in_inst;

    knockout_slice #(
        .W (32)
    ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .in_data   (slice_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_inst),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Next-state, counter and shadow-capture logic.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        sh_delay_nxt = sh_delay;
        sh_len_nxt   = sh_len;

        if (!arm) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt    = ST_ARMED;
                    cnt_nxt      = '0;
                    sh_delay_nxt = cfg_delay;
                    sh_len_nxt   = cfg_len;
                end
                ST_ARMED: begin
                    if (trig) begin
                        cnt_nxt = '0;
                        if (sh_delay != '0) begin
                            state_nxt = ST_DELAY;
                        end else if (sh_len != '0) begin
                            state_nxt = ST_KNOCK;
                        end else begin
                            state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DELAY: begin
                    if (beat) begin
                        if (cnt_inc == sh_delay) begin
                            cnt_nxt   = '0;
                            state_nxt = (sh_len == '0) ? ST_DONE : ST_KNOCK;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end
                ST_KNOCK: begin
                    if (beat) begin
                        if (cnt_inc == sh_len) begin
                            cnt_nxt   = '0;
                            state_nxt = ST_DONE;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_DONE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, counter, shadow and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sh_delay <= '0;
            sh_len   <= '0;
            active   <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sh_delay <= sh_delay_nxt;
            sh_len   <= sh_len_nxt;
            active   <= (state_nxt == ST_KNOCK);
            done     <= (state_nxt == ST_DONE);
        end
    end

`ifdef KNOCKOUT_CNT_EN
    // Saturating lifetime count of replaced beats; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            knocked_cnt <= 16'h0000;
        end else if (beat && (state == ST_KNOCK) && (knocked_cnt != 16'hFFFF)) begin
            knocked_cnt <= knocked_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_knockout_injector.sv
// Self-checking bench for knockout_injector: directed scenarios with literal
// expectations plus randomized traffic against a beat-index reference model.
module tb_knockout_injector;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        arm;
    logic        trig;
    logic [7:0]  cfg_delay;
    logic [7:0]  cfg_len;
    logic [31:0] in_inst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_inst;
    logic        out_valid;
    logic        out_ready;
    logic        active;
    logic        done;
`ifdef KNOCKOUT_CNT_EN
    logic [15:0] knocked_cnt;
`endif

    knockout_injector #(
        .NOP_INST (32'h0000_0013),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .trig      (trig),
        .cfg_delay (cfg_delay),
        .cfg_len   (cfg_len),
        .in_inst   (in_inst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_inst  (out_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .active    (active),
        .done      (done)
`ifdef KNOCKOUT_CNT_EN
        ,
        .knocked_cnt (knocked_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks beats accepted since the trigger; beats with
    // index in [delay, delay+len) are replaced.
    int          ph;      // 0 idle, 1 waiting for trigger, 2 triggered
    int          bcnt;
    int          mdly;
    int          mlen;
    logic        mv;
    logic [31:0] md;
    logic [15:0] kc;
    logic        m_beat;
    logic        m_knock;
    logic [31:0] log_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] stim_q[$];

    always @(posedge clk) begin
        if (out_valid && out_ready) log_q.push_back(out_inst);
        if (rst) begin
            ph = 0; bcnt = 0; mdly = 0; mlen = 0; mv = 1'b0; md = '0; kc = '0;
        end else begin
            m_beat  = in_valid && (!mv || out_ready);
            m_knock = (ph == 2) && (bcnt >= mdly) && (bcnt < mdly + mlen);
            if (m_beat) begin
                mv = 1'b1;
                md = m_knock ? NOP : in_inst;
                if (m_knock && kc != 16'hFFFF) kc = kc + 16'd1;
            end else if (out_ready) begin
                mv = 1'b0;
            end
            if (!arm) begin
                ph = 0; bcnt = 0;
            end else if (ph == 0) begin
                ph = 1; mdly = int'(cfg_delay); mlen = int'(cfg_len);
            end else if (ph == 1) begin
                if (trig) begin ph = 2; bcnt = 0; end
            end else if (m_beat && bcnt < mdly + mlen) begin
                bcnt++;
            end
        end
        #2;
        chk("out_valid", 32'(out_valid), 32'(mv));
        chk("out_inst", out_inst, md);
        chk("in_ready", 32'(in_ready), 32'(!mv || out_ready));
        chk("active", 32'(active),
            32'((ph == 2) && (bcnt >= mdly) && (bcnt < mdly + mlen)));
        chk("done", 32'(done), 32'((ph == 2) && (bcnt >= mdly + mlen)));
`ifdef KNOCKOUT_CNT_EN
        chk("knocked_cnt", 32'(knocked_cnt), 32'(kc));
`endif
    end

    task automatic chk_log(input string name);
        int n;
        chk({name, " count"}, 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk(name, log_q[i], exp_q[i]);
    endtask

    task automatic go_idle();
        @(negedge clk);
        arm = 1'b0; trig = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        log_q.delete();
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; trig = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Arm with the given config, pulse trig; returns at the negedge after.
    task automatic arm_and_trig(input logic [7:0] d, input logic [7:0] l);
        @(negedge clk);
        arm = 1'b1; cfg_delay = d; cfg_len = l;
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    // Offer stim_q in order; bp toggles out_ready 1,0,0,1. done_after > 0
    // additionally checks done against the number of beats accepted.
    task automatic send_stream(input bit bp, input int done_after);
        int idx = 0;
        int k   = 0;
        while (idx < stim_q.size() && k < 200) begin
            out_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            in_valid  = 1'b1;
            in_inst   = stim_q[idx];
            #1;
            if (in_ready) idx++;
            @(negedge clk);
            k++;
            if (done_after > 0) chk("done_after_beats", 32'(done), 32'(idx >= done_after));
        end
        if (idx < stim_q.size()) chk("stream timeout", 32'(idx), 32'(stim_q.size()));
        in_valid = 1'b0;
    endtask

    task automatic basic_run(input bit bp, input string name);
        go_idle();
        stim_q.delete();
        for (int i = 1; i <= 8; i++) stim_q.push_back(32'(i));
        arm_and_trig(8'd2, 8'd3);
        send_stream(bp, 5);
        drain();
        exp_q = '{32'd1, 32'd2, NOP, NOP, NOP, 32'd6, 32'd7, 32'd8};
        chk_log(name);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; trig = 1'b0; cfg_delay = '0; cfg_len = '0;
        in_inst = '0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_inst", out_inst, 32'd0);
        chk("rst active", 32'(active), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        basic_run(1'b0, "basic");
        basic_run(1'b1, "backpressure");
`ifdef KNOCKOUT_CNT_EN
        chk("knocked_cnt two runs", 32'(knocked_cnt), 32'd6);
`endif

        // Zero delay: first beat after trigger is replaced.
        go_idle();
        arm_and_trig(8'd0, 8'd1);
        chk("zero active before A", 32'(active), 32'd1);
        in_valid = 1'b1; in_inst = 32'hA; out_ready = 1'b1;
        @(negedge clk);
        chk("zero active after A", 32'(active), 32'd0);
        chk("zero done after A", 32'(done), 32'd1);
        in_inst = 32'hB;
        @(negedge clk);
        drain();
        exp_q = '{NOP, 32'hB};
        chk_log("zero_delay");

        // Abort after one of three NOPs.
        go_idle();
        arm_and_trig(8'd0, 8'd3);
        in_valid = 1'b1; in_inst = 32'h11;
        @(negedge clk);
        chk("abort active mid", 32'(active), 32'd1);
        in_valid = 1'b0; arm = 1'b0;
        @(negedge clk);
        chk("abort active", 32'(active), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        stim_q = '{32'h12, 32'h13};
        send_stream(1'b0, 0);
        drain();
        exp_q = '{NOP, 32'h12, 32'h13};
        chk_log("abort");
        chk("abort done end", 32'(done), 32'd0);

        // Trigger filtering: trig in IDLE, at arm rise, and during DELAY.
        go_idle();
        trig = 1'b1;
        @(negedge clk);
        arm = 1'b1; cfg_delay = 8'd3; cfg_len = 8'd1;
        @(negedge clk);
        trig = 1'b0; in_valid = 1'b1; in_inst = 32'h21;
        @(negedge clk);
        in_valid = 1'b0; trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_inst = 32'h30 + 32'(i); trig = (i == 2);
            @(negedge clk);
        end
        drain();
        exp_q = '{32'h21, 32'h31, 32'h32, 32'h33, NOP, 32'h35};
        chk_log("trig_filter");

        // Asynchronous reset in the middle of a knockout.
        go_idle();
        arm_and_trig(8'd0, 8'd3);
        in_valid = 1'b1; in_inst = 32'h41;
        @(negedge clk);
        chk("pre-rst active", 32'(active), 32'd1);
        in_valid = 1'b0; rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst out_inst", out_inst, 32'd0);
        chk("async rst active", 32'(active), 32'd0);
        chk("async rst done", 32'(done), 32'd0);
        chk("async rst in_ready", 32'(in_ready), 32'd1);
`ifdef KNOCKOUT_CNT_EN
        chk("async rst knocked_cnt", 32'(knocked_cnt), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0; arm = 1'b0;

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            arm       = ($urandom_range(0, 99) < 96);
            cfg_delay = 8'($urandom_range(0, 4));
            cfg_len   = 8'($urandom_range(0, 4));
            trig      = ($urandom_range(0, 7) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            in_inst   = $urandom;
        end
        go_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
